// File: rtl/mem_dump_reader.sv
// Post-halt memory read-out engine: walks START_ADDR..END_ADDR through the
// synchronous memory read port and emits each byte on a valid/ready stream.
module mem_dump_reader #(
  parameter int ADDR_W     = 12,
  parameter int START_ADDR = 8,
  parameter int END_ADDR   = 2047
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_en,
  input  logic [7:0]        m_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              start_ok;
  logic              accept;
  logic              at_end;

  // Stream handshake: a byte transfers on a rising edge where out_valid and
  // out_ready are both high; out_data/out_last hold while out_valid waits.
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign accept    = (state == S_SEND) && out_ready;
  assign at_end    = (addr == END_A);
  assign m_addr    = addr;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_CAP;
      S_CAP:   state_nxt = S_SEND;
      S_SEND:  if (accept) state_nxt = at_end ? S_DONE : S_REQ;
      S_DONE:  if (start_ok) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_rd      = 1'b0;
    m_en      = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_REQ, S_CAP: begin
        m_rd = 1'b1;
        m_en = 1'b1;
        busy = 1'b1;
      end
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // End-of-range compare happens before the increment, so addr never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (start_ok) begin
        addr       <= START_A;
        byte_count <= '0;
      end
      if (state == S_CAP) begin
        out_data <= m_rd_data;
        out_last <= at_end;
      end
      if (accept) begin
        byte_count <= byte_count + 1'b1;
        if (!at_end) addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: a small 8..15 instance for stream scenarios and a
// single-byte 4095..4095 instance for the top-of-address-space case.
module tb_mem_dump_reader;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start, start_e;
  logic          out_ready, out_ready_e;
  logic [AW-1:0] m_addr, m_addr_e;
  logic          m_rd, m_en, m_rd_e, m_en_e;
  logic [7:0]    rd_data, rd_data_e;
  logic          out_valid, out_last, busy, done;
  logic          out_valid_e, out_last_e, busy_e, done_e;
  logic [7:0]    out_data, out_data_e;
  logic [AW:0]   byte_count, byte_count_e;
  logic [2:0]    dbg_state, dbg_state_e;

  mem_dump_reader #(.ADDR_W(AW), .START_ADDR(8), .END_ADDR(15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .m_addr(m_addr), .m_rd(m_rd), .m_en(m_en), .m_rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done),
    .byte_count(byte_count), .dbg_state(dbg_state)
  );

  mem_dump_reader #(.ADDR_W(AW), .START_ADDR(4095), .END_ADDR(4095)) dut_e (
    .clk(clk), .reset(reset), .start(start_e),
    .m_addr(m_addr_e), .m_rd(m_rd_e), .m_en(m_en_e), .m_rd_data(rd_data_e),
    .out_valid(out_valid_e), .out_ready(out_ready_e), .out_data(out_data_e),
    .out_last(out_last_e), .busy(busy_e), .done(done_e),
    .byte_count(byte_count_e), .dbg_state(dbg_state_e)
  );

  // Synchronous memory: data appears the cycle after the read request.
  logic [7:0] mem [0:4095];
  always @(posedge clk) if (m_en && m_rd) rd_data <= mem[m_addr];
  always @(posedge clk) if (m_en_e && m_rd_e) rd_data_e <= mem[m_addr_e];

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];

  task automatic push_expected(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back({(a == hi), mem[a]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_e = 1'b0;
    out_ready = 1'b1; out_ready_e = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_addr, m_rd, m_en, out_valid, out_last, busy, done, out_data, byte_count} !== '0)
      $display("FAIL reset_outputs: addr=%h rd=%b en=%b v=%b l=%b busy=%b done=%b d=%h cnt=%0d, required all 0",
               m_addr, m_rd, m_en, out_valid, out_last, busy, done, out_data, byte_count);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d required 0", dbg_state);
    else n_pass++;
    n_checks++;
    if ({m_addr_e, m_rd_e, m_en_e, out_valid_e, out_last_e, busy_e, done_e, out_data_e, byte_count_e} !== '0)
      $display("FAIL reset_outputs_edge: addr=%h v=%b busy=%b done=%b cnt=%0d, required all 0",
               m_addr_e, out_valid_e, busy_e, done_e, byte_count_e);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    logic [8:0] e;
    exp_q.delete();
    push_expected(8, 15);
    out_ready = 1'b1;
    pulse_start();
    cyc = 1;
    n_checks++;
    if ({busy, m_rd, m_en, m_addr} !== {3'b111, 12'd8})
      $display("FAIL basic_req: busy/rd/en=%b%b%b addr=%h, required 111 addr 008", busy, m_rd, m_en, m_addr);
    else n_pass++;
    while (cyc <= 27) begin
      if (cyc == 2) begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_valid_early: got %b required 0 in T+2", out_valid);
        else n_pass++;
      end
      if (cyc == 3) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL basic_valid_t3: got %b required 1 in T+3", out_valid);
        else n_pass++;
      end
      if (cyc == 24) begin
        n_checks++;
        if (done !== 1'b0) $display("FAIL basic_done_early: got %b required 0 in T+24", done);
        else n_pass++;
      end
      if (cyc == 25) begin
        n_checks++;
        if ({done, byte_count} !== {1'b1, 13'd8})
          $display("FAIL basic_done_t25: done=%b cnt=%0d, required done=1 cnt=8", done, byte_count);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL basic_extra_byte: got %h, required no byte", out_data);
        else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e)
            $display("FAIL basic_byte: got last=%b data=%h required last=%b data=%h", out_last, out_data, e[8], e[7:0]);
          else n_pass++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL basic_missing: %0d bytes left, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_strobes();
    int phase, bnum;
    out_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= 24; c++) begin
      phase = (c - 1) % 3;
      bnum  = (c - 1) / 3;
      n_checks++;
      if ({m_rd, m_en, out_valid} !== ((phase < 2) ? 3'b110 : 3'b001))
        $display("FAIL strobe_pattern: cycle %0d rd/en/valid=%b%b%b required %b", c, m_rd, m_en, out_valid,
                 (phase < 2) ? 3'b110 : 3'b001);
      else n_pass++;
      if (phase < 2) begin
        n_checks++;
        if (m_addr !== AW'(8 + bnum)) $display("FAIL strobe_addr: cycle %0d got %h required %h", c, m_addr, 8 + bnum);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, m_rd, m_en, m_addr} !== {3'b100, 12'd15})
      $display("FAIL strobe_after: done/rd/en=%b%b%b addr=%h, required 100 addr 00f", done, m_rd, m_en, m_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int stall, stalled_0a, n_hs;
    logic seen_0a, prev_stall, prev_last, finished;
    logic [7:0] prev_data;
    logic [8:0] e;
    exp_q.delete();
    push_expected(8, 15);
    stall = 0; stalled_0a = 0; n_hs = 0;
    seen_0a = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = 8'h00; finished = 1'b0;
    pulse_start();
    for (int c = 0; c < 300 && !finished; c++) begin
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, prev_last, prev_data})
          $display("FAIL bp_stable: v=%b l=%b d=%h required v=1 l=%b d=%h", out_valid, out_last, out_data, prev_last, prev_data);
        else n_pass++;
      end
      if (out_valid && out_data == 8'h0A && !seen_0a) begin
        seen_0a = 1'b1;
        stall = 5;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else out_ready = 1'($urandom_range(0, 1));
      if (out_valid && !out_ready) begin
        n_checks++;
        if ({m_rd, m_en} !== 2'b00) $display("FAIL bp_rd_stalled: rd/en=%b%b required 00", m_rd, m_en);
        else n_pass++;
        if (out_data == 8'h0A) stalled_0a++;
      end
      if (out_valid && out_ready) begin
        n_hs++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_byte: got %h, required no byte", out_data);
        else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e)
            $display("FAIL bp_byte: got last=%b data=%h required last=%b data=%h", out_last, out_data, e[8], e[7:0]);
          else n_pass++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      finished   = done;
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_checks++;
    if (!finished || exp_q.size() != 0 || n_hs != 8 || byte_count !== 13'd8)
      $display("FAIL bp_complete: finished=%b left=%0d handshakes=%0d cnt=%0d, required 1/0/8/8",
               finished, exp_q.size(), n_hs, byte_count);
    else n_pass++;
    n_checks++;
    if (stalled_0a < 5) $display("FAIL bp_stall_0a: stalled %0d cycles on 0A, required at least 5", stalled_0a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_hs;
    logic finished;
    logic [8:0] e;
    exp_q.delete();
    push_expected(8, 15);
    n_hs = 0;
    out_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 60 && !(n_hs == 3 && out_valid); c++) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_last, out_data} !== e) $display("FAIL rst_pre_byte: got %h required %h", out_data, e[7:0]);
        else n_pass++;
        n_hs++;
        if (n_hs == 3) out_ready = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!(n_hs == 3 && out_valid === 1'b1))
      $display("FAIL rst_reach_send: handshakes=%0d valid=%b, required 3 and 1", n_hs, out_valid);
    else n_pass++;
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({m_addr, m_rd, m_en, out_valid, out_last, busy, done, out_data, byte_count, dbg_state} !== '0)
      $display("FAIL rst_mid_outputs: addr=%h v=%b busy=%b done=%b d=%h cnt=%0d st=%0d, required all 0",
               m_addr, out_valid, busy, done, out_data, byte_count, dbg_state);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, byte_count} !== '0) $display("FAIL rst_stays_idle: busy=%b cnt=%0d required 0/0", busy, byte_count);
    else n_pass++;
    exp_q.delete();
    push_expected(8, 15);
    pulse_start();
    finished = 1'b0;
    for (int c = 0; c < 60 && !finished; c++) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rst_extra_byte: got %h", out_data);
        else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) $display("FAIL rst_post_byte: got %h required %h", out_data, e[7:0]);
          else n_pass++;
        end
      end
      finished = done;
      @(negedge clk);
    end
    n_checks++;
    if (!finished || exp_q.size() != 0 || byte_count !== 13'd8)
      $display("FAIL rst_post_complete: finished=%b left=%0d cnt=%0d, required 1/0/8", finished, exp_q.size(), byte_count);
    else n_pass++;
  endtask

  task automatic test_edge();
    int n_hs;
    logic wrapped;
    n_hs = 0; wrapped = 1'b0;
    out_ready_e = 1'b1;
    start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if ((busy_e || done_e) && m_addr_e == '0) wrapped = 1'b1;
      if (out_valid_e && out_ready_e) begin
        n_hs++;
        n_checks++;
        if ({out_last_e, out_data_e} !== {1'b1, mem[4095]})
          $display("FAIL edge_byte: got last=%b data=%h required last=1 data=%h", out_last_e, out_data_e, mem[4095]);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_hs != 1 || done_e !== 1'b1 || byte_count_e !== 13'd1 || wrapped)
      $display("FAIL edge_complete: handshakes=%0d done=%b cnt=%0d wrapped=%b, required 1/1/1/0",
               n_hs, done_e, byte_count_e, wrapped);
    else n_pass++;
  endtask

  task automatic test_start_handling();
    int n_hs;
    logic finished, pulsed;
    logic [8:0] e;
    exp_q.delete();
    cap_q.delete();
    push_expected(8, 15);
    out_ready = 1'b1;
    n_hs = 0; pulsed = 1'b0; finished = 1'b0;
    pulse_start();
    for (int c = 0; c < 60 && !finished; c++) begin
      start = 1'b0;
      if (out_valid && n_hs == 2 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_hs++;
        cap_q.push_back({out_last, out_data});
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL start_send_extra: got %h", out_data);
        else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) $display("FAIL start_send_byte: got %h required %h", out_data, e[7:0]);
          else n_pass++;
        end
      end
      finished = done;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (!finished || n_hs != 8 || byte_count !== 13'd8)
      $display("FAIL start_send_ignored: finished=%b handshakes=%0d cnt=%0d, required 1/8/8", finished, n_hs, byte_count);
    else n_pass++;
    n_hs = 0; finished = 1'b0;
    pulse_start();
    for (int c = 0; c < 60 && !finished; c++) begin
      if (out_valid && out_ready) begin
        n_hs++;
        n_checks++;
        if (cap_q.size() == 0) $display("FAIL rerun_extra: got %h", out_data);
        else begin
          e = cap_q.pop_front();
          if ({out_last, out_data} !== e) $display("FAIL rerun_byte: got %h required %h", out_data, e[7:0]);
          else n_pass++;
        end
      end
      finished = done;
      @(negedge clk);
    end
    n_checks++;
    if (!finished || n_hs != 8 || cap_q.size() != 0)
      $display("FAIL rerun_complete: finished=%b handshakes=%0d left=%0d, required 1/8/0", finished, n_hs, cap_q.size());
    else n_pass++;
    pulse_start();
    for (int c = 0; c < 60 && !(out_valid && out_last); c++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b10) $display("FAIL start_at_last: done/busy=%b%b required 10", done, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy, m_rd} !== 3'b100) $display("FAIL start_at_last_hold: done/busy/rd=%b%b%b required 100", done, busy, m_rd);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
    test_reset();
    test_basic();
    test_strobes();
    test_backpressure();
    test_reset_mid();
    test_edge();
    test_start_handling();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
